readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_sequencer_pkg.sv | 24 ++
 rtl/readout_sequencer.sv | 151 +++++++++++++++
 tb/tb_readout_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : readout_sequencer_pkg
// Brief  : Shared logic-analyzer FSM state encoding and frame constants.
// Rev    : 1.0  initial release
// ============================================================================
package readout_sequencer_pkg;

  localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_POP    = 4'd2,
    ST_WAIT_Q = 4'd3,
    ST_DATA   = 4'd4,
    ST_CNT_HI = 4'd5,
    ST_CNT_LO = 4'd6,
    ST_CSUM   = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module : readout_sequencer
// Brief  : Drains sample words from a FIFO into a sync/data/count/xor framed
//          byte stream with valid/ready handshaking.
// Rev    : 1.0  initial release
// ============================================================================
module readout_sequencer
  import readout_sequencer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE,
  parameter int         MAX_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_mrst,
  input  logic        i_start,
  input  logic        i_run,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_q,
  output logic        o_fifo_rdreq,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam logic [15:0] C_MAX_WORDS = 16'(MAX_WORDS);

  state_t      r_state;
  logic        r_run_d;
  logic [15:0] r_count;
  logic [7:0]  r_csum;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_byte;
  logic        r_valid;
  logic        r_done;

  logic w_start;
  logic w_xfer;
  logic w_pop;

  assign w_start = i_start | (r_run_d & ~i_run);
  assign w_xfer  = r_valid & i_byte_ready;
  // The pop is issued straight from POP so the FIFO's one-cycle read latency
  // lands exactly in WAIT_Q; gating on the empty flag keeps it underflow-safe.
  assign w_pop   = (r_state == ST_POP) & ~i_fifo_empty & (r_count < C_MAX_WORDS);

  assign o_fifo_rdreq = w_pop;
  assign o_byte       = r_byte;
  assign o_byte_valid = r_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_done;

  always_ff @(posedge i_clk or posedge i_mrst) begin
    if (i_mrst) begin
      r_state <= ST_IDLE;
      r_run_d <= 1'b0;
      r_count <= 16'd0;
      r_csum  <= 8'd0;
      r_shift <= 32'd0;
      r_idx   <= 2'd0;
      r_byte  <= 8'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_run_d <= i_run;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_SYNC;
            r_count <= 16'd0;
            r_csum  <= 8'd0;
            r_byte  <= SYNC_BYTE;
            r_valid <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_state <= ST_POP;
          end
        end
        ST_POP: begin
          if (w_pop) begin
            r_state <= ST_WAIT_Q;
          end else begin
            r_byte  <= r_count[15:8];
            r_csum  <= r_csum ^ r_count[15:8];
            r_valid <= 1'b1;
            r_state <= ST_CNT_HI;
          end
        end
        ST_WAIT_Q: begin
          // Checksum accumulates as each byte is presented, so it is final
          // by the time the low count byte has been folded in.
          r_shift <= {i_fifo_q[23:0], 8'h00};
          r_byte  <= i_fifo_q[31:24];
          r_csum  <= r_csum ^ i_fifo_q[31:24];
          r_count <= r_count + 16'd1;
          r_idx   <= 2'd0;
          r_valid <= 1'b1;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_xfer) begin
            if (r_idx == 2'd3) begin
              r_valid <= 1'b0;
              r_state <= ST_POP;
            end else begin
              r_byte  <= r_shift[31:24];
              r_csum  <= r_csum ^ r_shift[31:24];
              r_shift <= {r_shift[23:0], 8'h00};
              r_idx   <= r_idx + 2'd1;
            end
          end
        end
        ST_CNT_HI: begin
          if (w_xfer) begin
            r_byte  <= r_count[7:0];
            r_csum  <= r_csum ^ r_count[7:0];
            r_state <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (w_xfer) begin
            r_byte  <= r_csum;
            r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_readout_sequencer
// Brief  : Self-checking bench with a FIFO model and a frame reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_readout_sequencer;

  localparam int MAXW = 2;

  logic        clk = 1'b0;
  logic        i_mrst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_run = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] q_reg = 32'd0;
  logic        o_fifo_rdreq;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready = 1'b1;
  logic        o_busy;
  logic        o_frame_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] mq[$];
  logic [7:0]  cap[$];
  int rdreq_cnt = 0;
  int done_cnt = 0;
  int under_cnt = 0;

  always #5 clk = ~clk;

  readout_sequencer #(.SYNC_BYTE(8'hA5), .MAX_WORDS(MAXW)) dut (
    .i_clk        (clk),
    .i_mrst       (i_mrst),
    .i_start      (i_start),
    .i_run        (i_run),
    .i_fifo_empty (fifo_empty),
    .i_fifo_q     (q_reg),
    .o_fifo_rdreq (o_fifo_rdreq),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  // FIFO with one-cycle read latency, plus transfer/pulse monitors
  always @(posedge clk) begin
    if (o_fifo_rdreq) begin
      rdreq_cnt++;
      if (fifo_q.size() > 0) q_reg <= fifo_q.pop_front();
      else under_cnt++;
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (o_byte_valid && i_byte_ready) cap.push_back(o_byte);
    if (o_frame_done) done_cnt++;
  end

  task automatic push_words(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      mq.push_back(w);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Drives one frame and checks it against the frame rules applied to the
  // words the model expects to be drained.
  task automatic run_frame(input string name, input bit use_run, input int hold_at,
                           input bit mid_start, input bit rand_ready);
    logic [31:0] words[$];
    logic [7:0]  exp[$];
    logic [7:0]  x, prev_b, b;
    int n, base, rd0, dn0, ud0, cyc, stall;
    bit prev_v, held;
    n = (mq.size() < MAXW) ? mq.size() : MAXW;
    for (int i = 0; i < n; i++) words.push_back(mq.pop_front());
    exp.push_back(8'hA5);
    x = 8'h00;
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'((words[i] >> (8 * k)) & 32'hFF);
        exp.push_back(b);
        x ^= b;
      end
    end
    exp.push_back(8'(n / 256));
    exp.push_back(8'(n % 256));
    x = x ^ 8'(n / 256) ^ 8'(n % 256);
    exp.push_back(x);

    base = cap.size(); rd0 = rdreq_cnt; dn0 = done_cnt; ud0 = under_cnt;
    i_byte_ready = 1'b0;
    if (use_run) begin
      i_run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_run = 1'b0;
    end else begin
      i_start = 1'b1;
    end
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, o_busy);
    end

    stall = 0; prev_v = 1'b0; held = 1'b0; prev_b = 8'h00; cyc = 0;
    while (done_cnt == dn0 && cyc < 4000) begin
      if (prev_v && !i_byte_ready) begin
        checks++;
        if (o_byte_valid !== 1'b1 || o_byte !== prev_b) begin
          errors++;
          $display("FAIL %s hold_stable: valid=%b byte=%h want valid=1 byte=%h",
                   name, o_byte_valid, o_byte, prev_b);
        end
      end
      prev_v = o_byte_valid;
      prev_b = o_byte;
      if (stall > 0) begin
        i_byte_ready = 1'b0;
        stall--;
      end else if (hold_at >= 0 && !held && (cap.size() - base) == hold_at) begin
        held = 1'b1;
        stall = 4;
        i_byte_ready = 1'b0;
      end else begin
        i_byte_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      i_start = mid_start && ((cap.size() - base) == 2);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    i_byte_ready = 1'b1;
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s timeout: no frame_done after %0d cycles", name, cyc);
    end
    repeat (10) @(negedge clk);

    checks++;
    if (cap.size() - base != exp.size()) begin
      errors++;
      $display("FAIL %s frame_len: got %0d want %0d", name, cap.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < cap.size(); i++) begin
      checks++;
      if (cap[base + i] !== exp[i]) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %h want %h", name, i, cap[base + i], exp[i]);
      end
    end
    checks++;
    if (done_cnt - dn0 != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - dn0);
    end
    checks++;
    if (rdreq_cnt - rd0 != n) begin
      errors++;
      $display("FAIL %s rdreq_pulses: got %0d want %0d", name, rdreq_cnt - rd0, n);
    end
    checks++;
    if (under_cnt != ud0) begin
      errors++;
      $display("FAIL %s rdreq_while_empty: got %0d want 0", name, under_cnt - ud0);
    end
    checks++;
    if (o_busy !== 1'b0 || o_byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b valid=%b want 0 0", name, o_busy, o_byte_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (o_byte_valid !== 1'b0 || o_fifo_rdreq !== 1'b0 || o_frame_done !== 1'b0 ||
        o_busy !== 1'b0 || o_byte !== 8'h00) begin
      errors++;
      $display("FAIL %s: valid=%b rdreq=%b done=%b busy=%b byte=%h want 0 0 0 0 00",
               name, o_byte_valid, o_fifo_rdreq, o_frame_done, o_busy, o_byte);
    end
  endtask

  task automatic test_reset();
    i_mrst = 1'b1;
    #1;
    check_reset_outputs("reset_values");
    repeat (2) @(negedge clk);
    i_mrst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_single_word();
    logic [7:0] want[8];
    int base;
    want = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h01, 8'h45};
    fifo_q.push_back(32'h11223344);
    mq.push_back(32'h11223344);
    @(negedge clk);
    @(negedge clk);
    base = cap.size();
    run_frame("single_word", 1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 8 && base + i < cap.size(); i++) begin
      checks++;
      if (cap[base + i] !== want[i]) begin
        errors++;
        $display("FAIL single_word_const[%0d]: got %h want %h", i, cap[base + i], want[i]);
      end
    end
  endtask

  task automatic test_empty_run();
    run_frame("empty_run", 1'b1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    push_words(1);
    run_frame("backpressure", 1'b0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_max_words();
    push_words(3);
    run_frame("max_words_a", 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (fifo_q.size() != 1) begin
      errors++;
      $display("FAIL max_words_left: got %0d want 1", fifo_q.size());
    end
    run_frame("max_words_b", 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_start();
    push_words(1);
    run_frame("mid_start", 1'b0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int base, rd0, cyc;
    push_words(2);
    base = cap.size();
    rd0 = rdreq_cnt;
    i_byte_ready = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while ((cap.size() - base) < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL reset_mid_timeout: reached %0d bytes want 3", cap.size() - base);
    end
    i_mrst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_frame");
    @(negedge clk);
    i_mrst = 1'b0;
    for (int i = 0; i < rdreq_cnt - rd0; i++) void'(mq.pop_front());
    @(negedge clk);
    run_frame("after_reset", 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      push_words($urandom_range(0, 3));
      run_frame("random", 1'($urandom_range(0, 1)), -1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_empty_run();
    test_backpressure();
    test_max_words();
    test_mid_start();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
